// File: rtl/mmio_pkg.sv
// mmio_pkg: register offsets, STATUS bit positions and register index enum for the
// CPU MMIO window, plus the byte-lane merge helper shared by the writable registers.
package mmio_pkg;

   localparam logic [5:0] MmioTxOffset         = 6'h00;
   localparam logic [5:0] MmioStatusOffset     = 6'h04;
   localparam logic [5:0] MmioRxOffset         = 6'h08;
   localparam logic [5:0] MmioRsvdOffset       = 6'h0C;
   localparam logic [5:0] MmioMtimeLoOffset    = 6'h10;
   localparam logic [5:0] MmioMtimeHiOffset    = 6'h14;
   localparam logic [5:0] MmioMtimecmpLoOffset = 6'h18;
   localparam logic [5:0] MmioMtimecmpHiOffset = 6'h1C;
   localparam logic [5:0] MmioMsipOffset       = 6'h20;
   localparam logic [5:0] MmioScratchOffset    = 6'h24;

   localparam int StatusTxFullBit   = 1;
   localparam int StatusTxEmptyBit  = 2;
   localparam int StatusOverflowBit = 3;
   localparam int StatusRxValidBit  = 4;

   typedef enum logic [3:0] {
      RegTx          = 4'd0,
      RegStatus      = 4'd1,
      RegRx          = 4'd2,
      RegRsvd        = 4'd3,
      RegMtimeLo     = 4'd4,
      RegMtimeHi     = 4'd5,
      RegMtimecmpLo  = 4'd6,
      RegMtimecmpHi  = 4'd7,
      RegMsip        = 4'd8,
      RegScratch     = 4'd9
   } mmio_reg_idx_e;

   function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
      logic [31:0] result;
      result = old_word;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) begin
            result[8*b +: 8] = new_word[8*b +: 8];
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count. A push while full succeeds only
// alongside a pop; a pop while empty is ignored, so push+pop on empty just pushes.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_push_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == CW'(DEPTH));
   assign o_empty   = (r_count == CW'(0));
   assign o_count   = r_count;
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Entry storage, written on an accepted push
   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_push_data;
      end
   end

   // Pointers and occupancy count
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Head byte reads as zero while empty
   always_comb begin
      if (o_empty) begin
         o_head = '0;
      end else begin
         o_head = r_mem[r_rd_ptr];
      end
   end

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: MMIO window with UART TX FIFO, RX holding register, machine timer,
// MSIP and scratch. Define MMIO_UART_RX_EN to build the UART receive path.
module mmio_responder #(
   parameter int          XLEN            = 32,
   parameter logic [31:0] MMIO_ADDR       = 32'h4000_0000,
   parameter logic [31:0] MMIO_SIZE_BYTES = 32'h0000_0028,
   parameter int          TX_FIFO_DEPTH   = 8,
   parameter int          TIMER_PRESCALE  = 1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [XLEN-1:0] i_addr,
   input  logic            i_rd_en,
   input  logic            i_wr_en,
   input  logic [XLEN-1:0] i_wr_data,
   input  logic [3:0]      i_byte_write_enable,
   output logic [XLEN-1:0] o_rd_data,
   output logic            o_uart_tx_valid,
   output logic [7:0]      o_uart_tx_data,
   input  logic            i_uart_tx_ready,
   input  logic            i_uart_rx_valid,
   input  logic [7:0]      i_uart_rx_data,
   output logic            o_timer_irq,
   output logic            o_soft_irq
);
   import mmio_pkg::*;

   localparam logic [31:0] MmioEnd = MMIO_ADDR + MMIO_SIZE_BYTES;
   localparam int PW = (TIMER_PRESCALE > 1) ? $clog2(TIMER_PRESCALE) : 1;
   localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

   mmio_reg_idx_e w_idx;
   logic          w_in_window;
   logic          w_rd;
   logic          w_wr;
   logic          w_tx_push;
   logic          w_tx_pop;
   logic          w_tx_full;
   logic          w_tx_empty;
   logic [CW-1:0] w_tx_count_unused;
   logic          w_rx_valid;
   logic [7:0]    w_rx_byte;
   logic          w_rx_ovf;
   logic          w_ovf_set;
   logic          w_ovf_clr;
   logic          w_tick;
   logic [63:0]   w_mtime_next;
   logic [31:0]   w_status;
   logic [31:0]   w_rd_val;

   logic [PW-1:0] r_presc;
   logic [63:0]   r_mtime;
   logic [63:0]   r_mtimecmp;
   logic [31:0]   r_mtime_shadow;
   logic [31:0]   r_scratch;
   logic [31:0]   r_rd_data;
   logic          r_overflow;
   logic          r_msip;
   logic          r_timer_irq;

   assign w_idx       = mmio_reg_idx_e'(i_addr[5:2]);
   assign w_in_window = (i_addr >= MMIO_ADDR) && (i_addr < MmioEnd);
   assign w_rd        = i_rd_en && w_in_window;
   assign w_wr        = i_wr_en && w_in_window;

   assign w_tx_push   = w_wr && (w_idx == RegTx) && i_byte_write_enable[0];
   assign w_tx_pop    = !w_tx_empty && i_uart_tx_ready;
   assign w_ovf_set   = (w_tx_push && w_tx_full && !w_tx_pop) || w_rx_ovf;
   assign w_ovf_clr   = w_wr && (w_idx == RegStatus) && i_byte_write_enable[0]
                        && i_wr_data[StatusOverflowBit];
   assign w_tick      = (r_presc == PW'(TIMER_PRESCALE - 1));

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (TX_FIFO_DEPTH)
   ) u_tx_fifo (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_push      (w_tx_push),
      .i_push_data (i_wr_data[7:0]),
      .i_pop       (w_tx_pop),
      .o_head      (o_uart_tx_data),
      .o_full      (w_tx_full),
      .o_empty     (w_tx_empty),
      .o_count     (w_tx_count_unused)
   );

`ifdef MMIO_UART_RX_EN
   logic       r_rx_valid;
   logic [7:0] r_rx_byte;

   // RX holding register: a strobe always captures, so it beats a same-cycle read clear
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_rx_valid <= 1'b0;
         r_rx_byte  <= 8'h00;
      end else if (i_uart_rx_valid) begin
         r_rx_valid <= 1'b1;
         r_rx_byte  <= i_uart_rx_data;
      end else if (w_rd && (w_idx == RegRx)) begin
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= r_rx_valid;
      end
   end

   assign w_rx_valid = r_rx_valid;
   assign w_rx_byte  = r_rx_byte;
   assign w_rx_ovf   = i_uart_rx_valid && r_rx_valid;
`else
   logic w_unused_rx;
   assign w_unused_rx = ^{i_uart_rx_valid, i_uart_rx_data};
   assign w_rx_valid  = 1'b0;
   assign w_rx_byte   = 8'h00;
   assign w_rx_ovf    = 1'b0;
`endif

   // Read mux over the pre-write register state
   always_comb begin
      w_status                    = 32'h0000_0000;
      w_status[StatusTxFullBit]   = w_tx_full;
      w_status[StatusTxEmptyBit]  = w_tx_empty;
      w_status[StatusOverflowBit] = r_overflow;
      w_status[StatusRxValidBit]  = w_rx_valid;
      w_rd_val                    = 32'h0000_0000;
      case (w_idx)
         RegStatus:     w_rd_val = w_status;
         RegRx:         w_rd_val = {23'h0, w_rx_valid, w_rx_byte};
         RegMtimeLo:    w_rd_val = r_mtime[31:0];
         RegMtimeHi:    w_rd_val = r_mtime_shadow;
         RegMtimecmpLo: w_rd_val = r_mtimecmp[31:0];
         RegMtimecmpHi: w_rd_val = r_mtimecmp[63:32];
         RegMsip:       w_rd_val = {31'h0, r_msip};
         RegScratch:    w_rd_val = r_scratch;
         default:       w_rd_val = 32'h0000_0000;
      endcase
   end

   // A software write to mtime replaces the increment for that cycle
   always_comb begin
      w_mtime_next = r_mtime;
      if (w_wr && (w_idx == RegMtimeLo)) begin
         w_mtime_next[31:0] = merge_bytes(r_mtime[31:0], i_wr_data, i_byte_write_enable);
      end else if (w_wr && (w_idx == RegMtimeHi)) begin
         w_mtime_next[63:32] = merge_bytes(r_mtime[63:32], i_wr_data, i_byte_write_enable);
      end else if (w_tick) begin
         w_mtime_next = r_mtime + 64'd1;
      end else begin
         w_mtime_next = r_mtime;
      end
   end

   // Register file, timer, read data and interrupt outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_presc        <= '0;
         r_mtime        <= 64'h0;
         r_mtimecmp     <= 64'hFFFF_FFFF_FFFF_FFFF;
         r_mtime_shadow <= 32'h0000_0000;
         r_scratch      <= 32'h0000_0000;
         r_rd_data      <= 32'h0000_0000;
         r_overflow     <= 1'b0;
         r_msip         <= 1'b0;
         r_timer_irq    <= 1'b0;
      end else begin
         r_presc     <= w_tick ? '0 : r_presc + PW'(1);
         r_mtime     <= w_mtime_next;
         r_timer_irq <= (r_mtime >= r_mtimecmp);
         if (w_rd) begin
            r_rd_data <= w_rd_val;
         end
         if (w_rd && (w_idx == RegMtimeLo)) begin
            r_mtime_shadow <= r_mtime[63:32];
         end
         if (w_ovf_set) begin
            r_overflow <= 1'b1;
         end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
         end
         if (w_wr) begin
            case (w_idx)
               RegMtimecmpLo: r_mtimecmp[31:0]  <= merge_bytes(r_mtimecmp[31:0], i_wr_data,
                                                               i_byte_write_enable);
               RegMtimecmpHi: r_mtimecmp[63:32] <= merge_bytes(r_mtimecmp[63:32], i_wr_data,
                                                               i_byte_write_enable);
               RegMsip:       r_msip <= i_byte_write_enable[0] ? i_wr_data[0] : r_msip;
               RegScratch:    r_scratch <= merge_bytes(r_scratch, i_wr_data, i_byte_write_enable);
               default:       r_scratch <= r_scratch;
            endcase
         end
      end
   end

   assign o_rd_data       = r_rd_data;
   assign o_uart_tx_valid = !w_tx_empty;
   assign o_timer_irq     = r_timer_irq;
   assign o_soft_irq      = r_msip;

endmodule
